// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the parametrised UART receiver.
//               Receiver state encoding, bit-timing helpers (cycles per bit,
//               mid-bit point) and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        COMMIT = 3'd5
    } uart_state_t;

    // The bit index counts data bits (up to 9) and stop bits (up to 2).
    localparam int unsigned C_MAX_BITS = 9;
    localparam int unsigned C_BIT_W    = $clog2(C_MAX_BITS + 1);

    // System clock cycles per serial bit.
    function automatic int unsigned calc_cpb(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Mid-bit cycle index; the majority samples sit at H-1, H and H+1.
    function automatic int unsigned calc_half(input int unsigned cpb);
        return cpb / 2;
    endfunction

    // Width of the bit-cycle counter that runs 0..cpb-1.
    function automatic int unsigned calc_k_w(input int unsigned cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_sampler
// Description : Front end of the UART receiver. 2-flop synchroniser (reset
//               to idle-high), falling-edge detector and 3-sample majority
//               vote taken at bit-cycle counts H-1, H and H+1.
// Ports       : clk_in, rst_in     - clock, async active-high reset
//               i_rx               - raw serial line
//               i_k                - bit-cycle counter from the FSM
//               i_sample_en        - high while a frame bit is being timed
//               o_rx_s             - synchronised line
//               o_fall_pulse       - rx_s went 1 -> 0 this cycle
//               o_decision         - majority value of the three samples
//               o_decision_valid   - o_decision is meaningful (k = H+1)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned H   = 2,
    parameter int unsigned K_W = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           i_rx,
    input  logic [K_W-1:0] i_k,
    input  logic           i_sample_en,
    output logic           o_rx_s,
    output logic           o_fall_pulse,
    output logic           o_decision,
    output logic           o_decision_valid
);

    localparam logic [K_W-1:0] C_K_S0  = K_W'(H - 1);
    localparam logic [K_W-1:0] C_K_S1  = K_W'(H);
    localparam logic [K_W-1:0] C_K_DEC = K_W'(H + 1);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_s0;
    logic r_s1;

    // History is kept in every state so an edge is never lost across
    // state transitions.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (i_k == C_K_S0) r_s0 <= r_sync2;
            if (i_k == C_K_S1) r_s1 <= r_sync2;
        end
    end

    assign o_rx_s           = r_sync2;
    assign o_fall_pulse     = r_prev & ~r_sync2;
    // Third sample is the live value at k = H+1.
    assign o_decision       = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign o_decision_valid = i_sample_en && (i_k == C_K_DEC);

endmodule
`default_nettype wire

// File: rtl/uart_rcv_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rcv_param
// Description : Parametrised UART receiver, 5..9 data bits LSB first, 1 or 2
//               stop bits, optional parity (macro UART_RCV_PARITY_EN).
//               Words are delivered through a single-entry valid/ready
//               holding register with framing/parity flags and an overrun
//               pulse when a completed word finds the register occupied.
// Ports       : clk_in, rst_in  - clock, async active-high reset
//               uart_rx         - raw serial line, idle high
//               data_out        - received word, right-aligned
//               valid_out       - word held in output register
//               ready_in        - consumer accept
//               frame_err_out   - stop bit sampled low (with data_out)
//               parity_err_out  - parity mismatch (with data_out)
//               overrun_out     - 1-cycle pulse, completed word dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rcv_param
    import uart_pkg::*;
#(
    parameter int CLOCK_SPEED = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 overrun_out
);

    localparam int unsigned CPB = calc_cpb(CLOCK_SPEED, BAUD_RATE);
    localparam int unsigned H   = calc_half(CPB);
    localparam int unsigned K_W = calc_k_w(CPB);

    localparam logic [K_W-1:0]     C_K_LAST    = K_W'(CPB - 1);
    localparam logic [C_BIT_W-1:0] C_DATA_LAST = C_BIT_W'(DATA_BITS - 1);
    localparam logic [C_BIT_W-1:0] C_STOP_LAST = C_BIT_W'(STOP_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_state_next;
    logic [K_W-1:0]         r_k;
    logic [C_BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_frame_err;
    logic                   r_pend;

    logic w_rx_s;
    logic w_fall;
    logic w_dec;
    logic w_dec_valid;
    logic w_bit_end;
    logic w_stop_done;
    logic w_false_start;
    logic w_sample_en;
    logic w_unused;

    assign w_sample_en = (r_state == START) || (r_state == DATA) ||
                         (r_state == PARITY) || (r_state == STOP);

    uart_bit_sampler #(
        .H   (H),
        .K_W (K_W)
    ) u_sampler (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .i_rx             (uart_rx),
        .i_k              (r_k),
        .i_sample_en      (w_sample_en),
        .o_rx_s           (w_rx_s),
        .o_fall_pulse     (w_fall),
        .o_decision       (w_dec),
        .o_decision_valid (w_dec_valid)
    );

    assign w_unused      = ^{w_rx_s, PARITY_ODD[0]};
    assign w_bit_end     = (r_k == C_K_LAST);
    assign w_stop_done   = (r_state == STOP) && w_dec_valid && (r_bit == C_STOP_LAST);
    assign w_false_start = (r_state == START) && w_dec_valid && w_dec;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_fall) w_state_next = START;
            START: begin
                if (w_false_start)  w_state_next = IDLE;
                else if (w_bit_end) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_end && (r_bit == C_DATA_LAST)) begin
`ifdef UART_RCV_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
            PARITY: if (w_bit_end) w_state_next = STOP;
            STOP:   if (w_stop_done) w_state_next = COMMIT;
            // A start edge seen during the final stop decision or during
            // COMMIT itself goes straight into the next frame.
            COMMIT: w_state_next = (r_pend || w_fall) ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_k         <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            r_pend <= (r_state == STOP) && w_fall;

            // The detecting IDLE cycle is k = 0 of the start bit, so the
            // counter enters START at 1.
            case (r_state)
                IDLE:   r_k <= w_fall ? K_W'(1) : '0;
                COMMIT: r_k <= r_pend ? (r_k + 1'b1) : (w_fall ? K_W'(1) : '0);
                default: begin
                    if (w_stop_done)        r_k <= w_fall ? K_W'(1) : '0;
                    else if (w_false_start) r_k <= '0;
                    else                    r_k <= w_bit_end ? '0 : (r_k + 1'b1);
                end
            endcase

            case (r_state)
                START: begin
                    r_bit       <= '0;
                    r_frame_err <= 1'b0;
                end
                DATA: begin
                    if (w_dec_valid) r_shift <= {w_dec, r_shift[DATA_BITS-1:1]};
                    if (w_bit_end)   r_bit <= (r_bit == C_DATA_LAST) ? '0 : (r_bit + 1'b1);
                end
                STOP: begin
                    if (w_dec_valid && !w_dec)     r_frame_err <= 1'b1;
                    if (w_bit_end && !w_stop_done) r_bit <= r_bit + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------- output register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            overrun_out <= 1'b0;
            if (r_state == COMMIT) begin
                // Accept-and-load in the same cycle replaces the held word.
                if (!valid_out || ready_in) begin
                    data_out      <= r_shift;
                    frame_err_out <= r_frame_err | (w_stop_done & ~w_dec);
                    valid_out     <= 1'b1;
                end else begin
                    overrun_out   <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef UART_RCV_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_par_err      <= 1'b0;
            parity_err_out <= 1'b0;
        end else begin
            if (r_state == START)
                r_par_err <= 1'b0;
            else if ((r_state == PARITY) && w_dec_valid)
                r_par_err <= (^r_shift) ^ w_dec ^ PARITY_ODD[0];
            if ((r_state == COMMIT) && (!valid_out || ready_in))
                parity_err_out <= r_par_err;
        end
    end
`else
    assign parity_err_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rcv_param.md
# uart_rcv_param

Parametrised UART receiver: the next generation of the team's serial receive path. It accepts a frame with configurable data width (5–9 bits) and 1 or 2 stop bits. Each bit is taken as a 3-sample majority vote at mid-bit, and glitches on the start bit are rejected. Each received word is delivered through a single-entry valid/ready holding register, with framing, parity and overrun status; the block sits between the board RX pin and the command/stream decoders.

## Interface
- CLOCK_SPEED, 100_000_000, system clock in Hz
- BAUD_RATE, 115_200, line rate in bit/s; CPB = CLOCK_SPEED/BAUD_RATE (integer division) must be ≥ 4
- DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
- STOP_BITS, 1, 1 or 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RCV_PARITY_EN)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- uart_rx  in  1  raw asynchronous serial line, idle high
- data_out  out  DATA_BITS  received word, right-aligned
- valid_out  out  1  word held in output register
- ready_in  in  1  consumer accepts word when valid_out && ready_in
- frame_err_out  out  1  qualifies data_out: a stop bit sampled low
- parity_err_out  out  1  qualifies data_out: parity mismatch
- overrun_out  out  1  one-cycle pulse: completed word dropped

## Operation
- uart_rx passes through a 2-flop synchroniser, reset to 1. All decisions use the synchronised signal rx_s.
- Bit timing: bit-cycle counter k runs 0..CPB-1; H = CPB/2. Samples are taken at k = H-1, H, H+1. The majority decision is made at k = H+1. The bit index advances at k = CPB-1, where k wraps to 0.
- States:
  - IDLE: k held at 0. A falling edge on rx_s (1 then 0) → START, with k = 0 on the first low cycle.
  - START: at decision, majority 1 → false start, back to IDLE, no output, no flag. Majority 0 → DATA at bit end.
  - DATA: shift in DATA_BITS decisions, LSB first. After the last bit → PARITY if enabled, else STOP.
  - PARITY: compute the parity error against the shifted data → STOP.
  - STOP: decide each stop bit; any 0 sets frame error. After the decision of the final stop bit → COMMIT immediately, without waiting for the end of the bit.
  - COMMIT (1 cycle): load the output register → IDLE.
- Output register:
  - Loaded in COMMIT if valid_out is low, or if valid_out && ready_in in that cycle (simultaneous accept and load: the new word replaces the old and valid_out stays 1).
  - Otherwise the new word is dropped, the held word and its flags are unchanged, and overrun_out pulses for exactly the COMMIT+1 cycle.
- frame_err_out and parity_err_out are loaded with data_out and are meaningful only while valid_out = 1.
- valid_out clears on valid_out && ready_in with no concurrent load.
- A frame with a framing error is still delivered, flagged. The receiver re-arms immediately; a line held low after a bad stop is treated as a new falling edge only after rx_s returns high.

## Timing
- Reset values: data_out = 0, valid_out = 0, all error flags = 0, overrun_out = 0, state = IDLE, synchroniser = 1.
- Reset mid-frame aborts the frame silently. The first frame after release requires a fresh falling edge.
- Latency:
  - Synchroniser: 2 cycles from the uart_rx edge to rx_s.
  - valid_out rises 2 cycles after the final stop-bit decision, at k = H+1 of that bit: 1 cycle to COMMIT, 1 cycle to the register.
- Back-to-back frames: a start edge arriving during COMMIT or at the bit end of STOP is still detected, because IDLE edge detection uses rx_s history registered in every state.

## Configuration
- UART_RCV_PARITY_EN defined: one parity bit follows the data. PARITY_ODD selects the expected sense, and a mismatch sets parity_err_out.
- UART_RCV_PARITY_EN undefined: no PARITY state and no parity bit expected; parity_err_out is tied to 0.

## Structure
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, COMMIT)
  - function computing CPB and H from the parameters
  - localparam widths for the bit and cycle counters, `$clog2`-based
- Sub-module uart_bit_sampler: 2-flop synchroniser, falling-edge detect, 3-sample majority at k = H-1/H/H+1. Outputs rx_s, fall_pulse and decision/decision_valid.

## Test plan
CLOCK_SPEED = 100M, BAUD_RATE = 25M (CPB = 4), DATA_BITS = 8, STOP_BITS = 1, 10 ns clock.
- Send 0x9F (bits 1,1,1,1,1,0,0,1), then stop, with ready_in = 1 → one valid_out pulse, data_out = 0x9F, all flags = 0.
- Drive a 10 ns low blip on idle, then a correct 0x9F frame → blip produces nothing; exactly one word 0x9F.
- Send 0x55 with the stop bit driven low → valid_out with data_out = 0x55 and frame_err_out = 1; the next frame 0xA0 is received clean.
- Hold ready_in = 0 and send 0x12 then 0x34 → data_out stays 0x12 and overrun_out pulses once; after the accept, valid_out = 0.
- With UART_RCV_PARITY_EN and PARITY_ODD = 0, send 0x03 with parity bit 1 → parity_err_out = 1; with parity 0 → 0.
- Assert rst_in in the middle of the DATA bits → outputs return to reset values within 1 cycle; the next full frame is received correctly.
